core_pipe_ctrl: RTL and testbench

CORE_PIPE_CTRL -- requirements
Module: core_pipe_ctrl

---
 rtl/core_pkg.sv | 16 +
 rtl/core_perf_counter.sv | 22 ++
 rtl/core_pipe_ctrl.sv | 106 ++++++++++
 tb/tb_core_pipe_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants and types for the core pipeline control slice.
package core_pkg;

  localparam int CORE_NUM_STAGES = 5;
  localparam int CORE_CNT_WIDTH  = 64;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [CORE_CNT_WIDTH-1:0] cycle;
    logic [CORE_CNT_WIDTH-1:0] retire;
    logic [CORE_CNT_WIDTH-1:0] stall;
    logic [CORE_CNT_WIDTH-1:0] flush;
  } core_perf_t;

endpackage

// File: rtl/core_perf_counter.sv
// Wrapping event counter with synchronous clear; clear wins over increment.
module core_perf_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/core_pipe_ctrl.sv
// In-order pipeline stall/flush/valid controller with optional performance
// counters (enabled by defining LETC_CORE_PERF_EN).
module core_pipe_ctrl
  import core_pkg::*;
#(
  parameter int NUM_STAGES = CORE_NUM_STAGES,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_valid_i,
  output logic                  fetch_ready_o,
  input  logic [NUM_STAGES-1:0] stage_busy_i,
  input  logic [NUM_STAGES-1:0] flush_req_i,
  output logic [NUM_STAGES-1:0] stage_valid_o,
  output logic [NUM_STAGES-1:0] stage_advance_o,
  output logic [NUM_STAGES-1:0] stage_kill_o,
  output logic                  retire_o,
  input  logic                  perf_clear_i,
  output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
  output logic [CNT_WIDTH-1:0]  retire_cnt_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

  logic [NUM_STAGES-1:0] valid;
  logic [NUM_STAGES-1:0] valid_next;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] kill;
  logic [NUM_STAGES-1:0] advance;
  logic [NUM_STAGES-1:0] feed;
  logic [NUM_STAGES-1:0] flush_live;
  logic                  accepted;

  assign flush_live = flush_req_i & valid;

  // Walk oldest to youngest: stall ripples down from older stages, kill
  // collects every live flush seen at a strictly older stage.
  always_comb begin
    logic s_acc;
    logic k_acc;
    s_acc = 1'b0;
    k_acc = 1'b0;
    stall = '0;
    kill  = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      s_acc    = valid[i] & (stage_busy_i[i] | s_acc);
      stall[i] = s_acc;
      kill[i]  = k_acc;
      k_acc    = k_acc | flush_live[i];
    end
  end

  assign advance         = valid & ~stall & ~kill;
  assign fetch_ready_o   = ~stall[0] & ~kill[0];
  assign accepted        = fetch_valid_i & fetch_ready_o;
  assign feed            = {advance[NUM_STAGES-2:0], accepted};
  assign stage_valid_o   = valid;
  assign stage_advance_o = advance;
  assign stage_kill_o    = kill;
  assign retire_o        = advance[NUM_STAGES-1];

  always_comb begin
    valid_next = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      if (kill[j]) begin
        valid_next[j] = 1'b0;
      end else if (stall[j]) begin
        valid_next[j] = valid[j];
      end else begin
        valid_next[j] = feed[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      valid <= valid_next;
    end
  end

`ifdef LETC_CORE_PERF_EN
  core_perf_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clear(perf_clear_i), .count(cycle_cnt_o)
  );
  core_perf_counter #(.WIDTH(CNT_WIDTH)) u_retire_cnt (
    .clk(clk), .rst_n(rst_n), .en(retire_o), .clear(perf_clear_i), .count(retire_cnt_o)
  );
  core_perf_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .en(|stall), .clear(perf_clear_i), .count(stall_cnt_o)
  );
  core_perf_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .en(|kill), .clear(perf_clear_i), .count(flush_cnt_o)
  );
`else
  logic unused_perf_clear;
  assign unused_perf_clear = perf_clear_i;
  assign cycle_cnt_o  = '0;
  assign retire_cnt_o = '0;
  assign stall_cnt_o  = '0;
  assign flush_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Randomized self-checking bench for core_pipe_ctrl against an occupancy model.
module tb_core_pipe_ctrl;

  localparam int NS = 5;
  localparam int CW = 8;
`ifdef LETC_CORE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_valid = 1'b0;
  logic          fetch_ready;
  logic [NS-1:0] busy = '0;
  logic [NS-1:0] flush = '0;
  logic [NS-1:0] v_o, a_o, k_o;
  logic          retire;
  logic          clr = 1'b0;
  logic [CW-1:0] cyc_o, ret_o, stl_o, fl_o;

  int errors = 0;
  int checks = 0;

  // model state: instruction id per stage, -1 = empty
  int            occ[NS];
  int            next_id = 0;
  logic [CW-1:0] c_cyc = '0, c_ret = '0, c_stl = '0, c_fl = '0;
  logic [NS-1:0] m_vld, m_stall, m_kill, m_adv;
  logic          m_ready;

  always #5 clk = ~clk;

  core_pipe_ctrl #(.NUM_STAGES(NS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready),
    .stage_busy_i(busy), .flush_req_i(flush),
    .stage_valid_o(v_o), .stage_advance_o(a_o), .stage_kill_o(k_o),
    .retire_o(retire), .perf_clear_i(clr),
    .cycle_cnt_o(cyc_o), .retire_cnt_o(ret_o), .stall_cnt_o(stl_o), .flush_cnt_o(fl_o)
  );

  function automatic logic [4*CW-1:0] exp_cnt();
    return PERF ? {c_cyc, c_ret, c_stl, c_fl} : '0;
  endfunction

  // Stall: a stage is stuck if some busy stage sits at or ahead of it with
  // no gap in between. Kill: everything younger than the oldest live flusher.
  task automatic model_eval();
    int f;
    f = -1;
    for (int i = 0; i < NS; i++) m_vld[i] = (occ[i] >= 0);
    for (int i = 0; i < NS; i++) if (flush[i] && m_vld[i]) f = i;
    for (int j = 0; j < NS; j++) m_kill[j] = (j < f);
    for (int i = 0; i < NS; i++) begin
      m_stall[i] = 1'b0;
      for (int k = i; k < NS; k++) begin
        if (!m_vld[k]) break;
        if (busy[k]) begin
          m_stall[i] = 1'b1;
          break;
        end
      end
    end
    m_adv   = m_vld & ~m_stall & ~m_kill;
    m_ready = !m_stall[0] && !m_kill[0];
  endtask

  task automatic model_update();
    int nocc[NS];
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) occ[i] = -1;
      c_cyc = '0; c_ret = '0; c_stl = '0; c_fl = '0;
    end else begin
      for (int j = 0; j < NS; j++) begin
        if (m_kill[j]) nocc[j] = -1;
        else if (m_stall[j]) nocc[j] = occ[j];
        else if (j == 0) begin
          if (fetch_valid && m_ready) begin
            nocc[j] = next_id;
            next_id++;
          end else nocc[j] = -1;
        end else nocc[j] = m_adv[j-1] ? occ[j-1] : -1;
      end
      for (int j = 0; j < NS; j++) occ[j] = nocc[j];
      if (clr) begin
        c_cyc = '0; c_ret = '0; c_stl = '0; c_fl = '0;
      end else begin
        c_cyc = c_cyc + 1'b1;
        if (m_adv[NS-1]) c_ret = c_ret + 1'b1;
        if (|m_stall) c_stl = c_stl + 1'b1;
        if (|m_kill) c_fl = c_fl + 1'b1;
      end
    end
  endtask

  task automatic drive(input logic rn, input logic fv, input logic [NS-1:0] b,
                       input logic [NS-1:0] f, input logic c);
    @(negedge clk);
    rst_n = rn; fetch_valid = fv; busy = b; flush = f; clr = c;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic fill();
    drive(1'b0, 1'b0, '0, '0, 1'b0); tick();
    for (int i = 0; i < NS; i++) begin
      drive(1'b1, 1'b1, '0, '0, 1'b0); tick();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NS; i++) occ[i] = -1;
    drive(1'b0, 1'b0, '0, '0, 1'b0); tick();
    drive(1'b0, 1'b1, '1, '1, 1'b0); tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    checks++;
    if (v_o !== '0 || a_o !== '0 || k_o !== '0 || retire !== 1'b0 || fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl got v=%b a=%b k=%b ret=%b rdy=%b want 0 0 0 0 1",
               v_o, a_o, k_o, retire, fetch_ready);
    end
    checks++;
    if ({cyc_o, ret_o, stl_o, fl_o} !== '0) begin
      errors++;
      $display("FAIL reset_cnt got %h want 0", {cyc_o, ret_o, stl_o, fl_o});
    end
    tick();
  endtask

  task automatic test_fill();
    drive(1'b0, 1'b0, '0, '0, 1'b0); tick();
    for (int e = 0; e < 14; e++) begin
      drive(1'b1, 1'b1, '0, '0, 1'b0);
      checks++;
      if (retire !== (e >= NS)) begin
        errors++;
        $display("FAIL fill_retire edge=%0d got %b want %b", e, retire, (e >= NS));
      end
      tick();
    end
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    checks++;
    if (ret_o !== (PERF ? c_ret : '0) || v_o !== 5'b11111) begin
      errors++;
      $display("FAIL fill_count got ret_cnt=%0d v=%b want ret_cnt=%0d v=11111",
               ret_o, v_o, PERF ? c_ret : '0);
    end
    tick();
  endtask

  task automatic test_busy();
    fill();
    drive(1'b1, 1'b1, 5'b00100, '0, 1'b0);
    checks++;
    if (a_o !== 5'b11000 || fetch_ready !== 1'b0 || k_o !== '0) begin
      errors++;
      $display("FAIL busy_hold got a=%b rdy=%b k=%b want 11000 0 00000", a_o, fetch_ready, k_o);
    end
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    checks++;
    if (v_o !== 5'b10111) begin
      errors++;
      $display("FAIL busy_next got v=%b want 10111", v_o);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [CW-1:0] fl_before;
    fill();
    drive(1'b1, 1'b1, '0, 5'b01000, 1'b0);
    fl_before = fl_o;
    checks++;
    if (k_o !== 5'b00111 || fetch_ready !== 1'b0 || a_o !== 5'b11000) begin
      errors++;
      $display("FAIL flush_kill got k=%b rdy=%b a=%b want 00111 0 11000", k_o, fetch_ready, a_o);
    end
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    checks++;
    if (v_o !== 5'b10000) begin
      errors++;
      $display("FAIL flush_next got v=%b want 10000", v_o);
    end
    checks++;
    if (fl_o !== (PERF ? fl_before + 1'b1 : '0)) begin
      errors++;
      $display("FAIL flush_cnt got %0d want %0d", fl_o, PERF ? fl_before + 1'b1 : '0);
    end
    tick();
  endtask

  task automatic test_multi_flush();
    fill();
    drive(1'b1, 1'b1, '0, 5'b10010, 1'b0);
    checks++;
    if (k_o !== 5'b01111) begin
      errors++;
      $display("FAIL multi_flush got k=%b want 01111", k_o);
    end
    tick();
    drive(1'b1, 1'b1, '0, '0, 1'b0); tick();
    drive(1'b1, 1'b1, '0, 5'b00100, 1'b0);
    checks++;
    if (v_o !== 5'b00001 || k_o !== '0 || a_o !== 5'b00001) begin
      errors++;
      $display("FAIL dead_flush got v=%b k=%b a=%b want 00001 00000 00001", v_o, k_o, a_o);
    end
    tick();
  endtask

  task automatic test_counter_wrap();
    drive(1'b0, 1'b0, '0, '0, 1'b0); tick();
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, 1'b0, '0, '0, 1'b0); tick();
    end
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    checks++;
    if (cyc_o !== (PERF ? 8'd255 : 8'd0)) begin
      errors++;
      $display("FAIL wrap_top got %0d want %0d", cyc_o, PERF ? 8'd255 : 8'd0);
    end
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    checks++;
    if (cyc_o !== 8'd0) begin
      errors++;
      $display("FAIL wrap_zero got %0d want 0", cyc_o);
    end
    tick();
    fill();
    drive(1'b1, 1'b1, '0, '0, 1'b1);
    checks++;
    if (retire !== 1'b1) begin
      errors++;
      $display("FAIL clr_retire got %b want 1", retire);
    end
    tick();
    drive(1'b1, 1'b1, '0, '0, 1'b0);
    checks++;
    if ({cyc_o, ret_o, stl_o, fl_o} !== '0) begin
      errors++;
      $display("FAIL clr_cnt got %h want 0", {cyc_o, ret_o, stl_o, fl_o});
    end
    tick();
  endtask

  task automatic test_mid_reset();
    fill();
    drive(1'b1, 1'b1, 5'b00010, '0, 1'b0); tick();
    drive(1'b0, 1'b1, '0, '0, 1'b0); tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    checks++;
    if (v_o !== '0 || retire !== 1'b0 || fetch_ready !== 1'b1 || {cyc_o, ret_o, stl_o, fl_o} !== '0) begin
      errors++;
      $display("FAIL mid_reset got v=%b ret=%b rdy=%b cnt=%h want 0 0 1 0",
               v_o, retire, fetch_ready, {cyc_o, ret_o, stl_o, fl_o});
    end
    tick();
  endtask

  task automatic test_random();
    logic          rn, fv, c;
    logic [NS-1:0] b, f;
    for (int n = 0; n < 400; n++) begin
      rn = ($urandom_range(0, 99) != 0);
      fv = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NS; i++) begin
        b[i] = ($urandom_range(0, 5) == 0);
        f[i] = ($urandom_range(0, 11) == 0);
      end
      drive(rn, fv, b, f, c);
      checks++;
      if (v_o !== m_vld || a_o !== m_adv || k_o !== m_kill ||
          fetch_ready !== m_ready || retire !== m_adv[NS-1]) begin
        errors++;
        $display("FAIL rand_ctrl n=%0d got v=%b a=%b k=%b rdy=%b ret=%b want v=%b a=%b k=%b rdy=%b ret=%b",
                 n, v_o, a_o, k_o, fetch_ready, retire, m_vld, m_adv, m_kill, m_ready, m_adv[NS-1]);
      end
      checks++;
      if ({cyc_o, ret_o, stl_o, fl_o} !== exp_cnt()) begin
        errors++;
        $display("FAIL rand_cnt n=%0d got %h want %h", n, {cyc_o, ret_o, stl_o, fl_o}, exp_cnt());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_busy();
    test_flush();
    test_multi_flush();
    test_counter_wrap();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
